// File: rtl/rd_burst_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO read port among NREQ rd_clk consumers.
// Optional empty-stall abort is enabled by defining RD_BURST_ARB_TIMEOUT_EN (adds port 'timeout').
module rd_burst_arbiter #(
  parameter int NREQ    = 4,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*LEN_W-1:0]    req_len,
  output logic [NREQ-1:0]          grant,
  input  logic                     fifo_empty,
  input  logic [DATA_W-1:0]        fifo_rd_data,
  output logic                     fifo_rd_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [$clog2(NREQ)-1:0]  out_id,
  output logic                     out_last,
  output logic                     busy
`ifdef RD_BURST_ARB_TIMEOUT_EN
  ,
  output logic                     timeout
`endif
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [LEN_W:0] REM_ONE = 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("rd_burst_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t          state, state_d;
  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  cur_id;
  logic [LEN_W:0]  remaining;

  logic            win_found;
  logic [IDW-1:0]  win_id;
  logic [IDW-1:0]  cand;
  logic [LEN_W-1:0] win_len;
  logic [NREQ-1:0] win_onehot;

  logic            pop;
  logic            last_pop;
  logic            tmo_hit;

  // Search upward from the slot after the last winner, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_len   = '0;
    cand      = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IDW'((32'(rr_ptr) + i) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
        win_len   = req_len[32'(cand)*LEN_W +: LEN_W];
      end
    end
  end

  assign win_onehot = NREQ'(1) << win_id;

  assign pop        = (state == BURST) && !fifo_empty && (!out_valid || out_ready);
  assign last_pop   = pop && (remaining == REM_ONE);
  assign fifo_rd_en = pop;
  assign busy       = (state == BURST) || out_valid;

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (win_found) state_d = BURST;
      BURST:   if (last_pop || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      rr_ptr    <= IDW'(NREQ - 1);
      cur_id    <= '0;
      remaining <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && win_found) begin
        cur_id    <= win_id;
        remaining <= {1'b0, win_len} + REM_ONE;
        rr_ptr    <= win_id;
        grant     <= win_onehot;
      end else if (last_pop || tmo_hit) begin
        grant <= '0;
      end

      // A pop reloads the output register even when the held word is accepted this cycle.
      if (pop) begin
        out_valid <= 1'b1;
        out_data  <= fifo_rd_data;
        out_id    <= cur_id;
        out_last  <= (remaining == REM_ONE);
        remaining <= remaining - REM_ONE;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RD_BURST_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] stall_cnt;

  // Abort fires on the edge where the count of empty BURST cycles reaches TIMEOUT.
  assign tmo_hit = (state == BURST) && fifo_empty && (stall_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge rd_clk or negedge rd_rst) begin
    if (!rd_rst) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= tmo_hit;
      if (state != BURST || pop || tmo_hit) begin
        stall_cnt <= '0;
      end else if (fifo_empty) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

endmodule
